// File: rtl/fifo_stream_pkg.sv
// Shared types and default widths for the FIFO drain / byte stream path.
package fifo_stream_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } ser_state_t;
endpackage

// File: rtl/ser_byte_sel.sv
// Combinational byte picker: returns symbol idx of a word, MSB-first or LSB-first.
module ser_byte_sel #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  output logic [BYTE_W-1:0] sel
);
  localparam int NB = DATA_W / BYTE_W;

  always_comb begin
    sel = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx == IDX_W'(k)) begin
        if (MSB_FIRST != 0) sel = word[DATA_W-1-k*BYTE_W -: BYTE_W];
        else                sel = word[k*BYTE_W +: BYTE_W];
      end
    end
  end
endmodule

// File: rtl/fifo_word_serializer.sv
// Pops one FIFO word at a time and streams it out as BYTE_W symbols over valid/ready.
// Optional SER_PARITY_EN adds a registered even-parity bit byte_par alongside byte_out.
module fifo_word_serializer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent,
`ifdef SER_PARITY_EN
  output logic              byte_par,
`endif
  output logic [1:0]        dbg_state
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  // Handshake: a byte moves on a posedge where byte_valid & byte_ready; once
  // byte_valid rises it stays high, with byte_out frozen, until that transfer.
  ser_state_t        state, state_nxt;
  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sel_word;
  logic [IDX_W-1:0]  sel_idx;
  logic [BYTE_W-1:0] sel_byte;
  logic              xfer;
  logic              last;

  assign xfer      = byte_valid & byte_ready;
  assign last      = (idx == LAST_IDX);
  assign dbg_state = state;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_rd) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (xfer && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The LOAD path picks byte 0 straight from fifo_data; SEND picks the next byte of the held word.
  always_comb begin
    fifo_rd  = (state == IDLE) & EN & ~fifo_empty & ~Rst;
    busy     = (state != IDLE);
    sel_word = (state == LOAD) ? fifo_data : word_q;
    sel_idx  = (state == LOAD) ? '0 : idx + IDX_W'(1);
  end

  ser_byte_sel #(
    .DATA_W   (DATA_W),
    .BYTE_W   (BYTE_W),
    .MSB_FIRST(MSB_FIRST),
    .IDX_W    (IDX_W)
  ) u_sel (
    .word(sel_word),
    .idx (sel_idx),
    .sel (sel_byte)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      word_q     <= '0;
      idx        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      words_sent <= '0;
`ifdef SER_PARITY_EN
      byte_par   <= 1'b0;
`endif
    end else if (state == LOAD) begin
      word_q     <= fifo_data;
      idx        <= '0;
      byte_out   <= sel_byte;
      byte_valid <= 1'b1;
`ifdef SER_PARITY_EN
      byte_par   <= ^sel_byte;
`endif
    end else if (state == SEND && xfer) begin
      if (last) begin
        byte_valid <= 1'b0;
        words_sent <= words_sent + CNT_W'(1);
      end else begin
        idx      <= idx + IDX_W'(1);
        byte_out <= sel_byte;
`ifdef SER_PARITY_EN
        byte_par <= ^sel_byte;
`endif
      end
    end
  end
endmodule
